cpu_lv1_protocol_monitor: RTL and testbench

- Synthesizable, parametrised protocol monitor for the CPU-to-L1 request interface and the proc-grant arbitration of the N-core MESI cache.
- Replaces ad-hoc per-core bench checks with a per-core FSM that does three things:
  - tracks every read/write transaction to completion;
  - enforces read/write timeouts;
  - flags protocol violations.
- Sits beside cache_top, passively observing the per-core interface bundles and the system-bus proc req/gnt vectors. It reports sticky error flags and per-core completion counters to the bench or an on-chip debug register bank.

---
 rtl/cpu_lv1_mon_pkg.sv | 24 ++
 rtl/cpu_lv1_protocol_monitor_if.sv | 36 +++
 rtl/cpu_lv1_core_tracker.sv | 125 ++++++++++++
 rtl/cpu_lv1_protocol_monitor.sv | 80 ++++++++
 tb/tb_cpu_lv1_protocol_monitor.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_lv1_mon_pkg.sv
// Shared types and constants for the CPU-to-L1 protocol monitor.
// Also provides the helper that sizes the per-core wait counter.
package cpu_lv1_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT,
      DONE_WAIT,
      TO_HOLD
   } mon_state_t;

   localparam int unsigned DEF_READ_TIMEOUT  = 80;
   localparam int unsigned DEF_WRITE_TIMEOUT = 90;

   // Wide enough to hold the larger of the two timeouts.
   function automatic int unsigned wait_cnt_width(input int unsigned rd_to,
                                                  input int unsigned wr_to);
      int unsigned max_to;
      max_to = (rd_to > wr_to) ? rd_to : wr_to;
      return $clog2(max_to + 1);
   endfunction

endpackage

// File: rtl/cpu_lv1_protocol_monitor_if.sv
// CPU/L1 request bundle and proc req/gnt vectors observed by the monitor.
// The master side drives every signal; the slave side only observes.
interface cpu_lv1_protocol_monitor_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned ADDR_WID  = 32
) ();

   logic [NUM_CORES-1:0]          cpu_rd;
   logic [NUM_CORES-1:0]          cpu_wr;
   logic [NUM_CORES-1:0]          cpu_wr_done;
   logic [NUM_CORES-1:0]          data_in_bus_cpu_lv1;
   logic [NUM_CORES*ADDR_WID-1:0] addr_bus_cpu_lv1;
   logic [NUM_CORES-1:0]          bus_lv1_lv2_req_proc;
   logic [NUM_CORES-1:0]          bus_lv1_lv2_gnt_proc;

   modport master (
      output cpu_rd,
      output cpu_wr,
      output cpu_wr_done,
      output data_in_bus_cpu_lv1,
      output addr_bus_cpu_lv1,
      output bus_lv1_lv2_req_proc,
      output bus_lv1_lv2_gnt_proc
   );

   modport slave (
      input cpu_rd,
      input cpu_wr,
      input cpu_wr_done,
      input data_in_bus_cpu_lv1,
      input addr_bus_cpu_lv1,
      input bus_lv1_lv2_req_proc,
      input bus_lv1_lv2_gnt_proc
   );

endinterface

// File: rtl/cpu_lv1_core_tracker.sv
// Per-core transaction tracker: FSM, wait counter, address latch,
// completion counter and sticky per-core error flags.
module cpu_lv1_core_tracker
   import cpu_lv1_mon_pkg::*;
#(
   parameter int unsigned ADDR_WID      = 32,
   parameter int unsigned READ_TIMEOUT  = DEF_READ_TIMEOUT,
   parameter int unsigned WRITE_TIMEOUT = DEF_WRITE_TIMEOUT,
   parameter int unsigned CNT_WID       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_rd,
   input  logic                cpu_wr,
   input  logic                cpu_wr_done,
   input  logic                data_in_bus_cpu_lv1,
   input  logic [ADDR_WID-1:0] addr,
   input  logic                clr_err,
   output logic                busy,
   output logic                err_timeout,
   output logic                err_rdwr,
   output logic                err_proto,
   output logic                err_any_next,
   output logic [CNT_WID-1:0]  txn_done_cnt
);

   localparam int unsigned WAIT_WID = wait_cnt_width(READ_TIMEOUT, WRITE_TIMEOUT);
   localparam logic [WAIT_WID-1:0] RD_LAST  = WAIT_WID'(READ_TIMEOUT - 1);
   localparam logic [WAIT_WID-1:0] WR_LAST  = WAIT_WID'(WRITE_TIMEOUT - 1);
   localparam logic [WAIT_WID-1:0] WAIT_MAX = '1;

   mon_state_t          state_q, state_d;
   logic [WAIT_WID-1:0] wait_q, wait_d;
   logic [ADDR_WID-1:0] addr_q, addr_d;
   logic [CNT_WID-1:0]  cnt_q, cnt_d;
   logic                to_q, to_d;
   logic                rdwr_q, rdwr_d;
   logic                proto_q, proto_d;
   logic                set_to, set_proto;

   logic                is_rd, done, req_ok;
   logic [WAIT_WID-1:0] last;

   assign is_rd  = (state_q == RD_WAIT);
   assign done   = is_rd ? data_in_bus_cpu_lv1 : cpu_wr_done;
   assign req_ok = is_rd ? (cpu_rd && !cpu_wr) : (cpu_wr && !cpu_rd);
   assign last   = is_rd ? RD_LAST : WR_LAST;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      set_to    = 1'b0;
      set_proto = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu_rd && !cpu_wr) begin
               state_d = RD_WAIT;
               wait_d  = '0;
               addr_d  = addr;
            end else if (cpu_wr && !cpu_rd) begin
               state_d = WR_WAIT;
               wait_d  = '0;
               addr_d  = addr;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (wait_q != WAIT_MAX) begin
               wait_d = wait_q + 1'b1;
            end
            // Completion wins over both protocol and timeout checks.
            if (done) begin
               state_d = DONE_WAIT;
               cnt_d   = cnt_q + 1'b1;
            end else if (!req_ok || (addr != addr_q)) begin
               state_d   = IDLE;
               set_proto = 1'b1;
            end else if (wait_q == last) begin
               state_d = TO_HOLD;
               set_to  = 1'b1;
            end
         end
         DONE_WAIT, TO_HOLD: begin
            if (!cpu_rd && !cpu_wr) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A fresh violation in the clearing cycle keeps its flag set.
   assign to_d    = (to_q & ~clr_err) | set_to;
   assign rdwr_d  = (rdwr_q & ~clr_err) | (cpu_rd & cpu_wr);
   assign proto_d = (proto_q & ~clr_err) | set_proto;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         rdwr_q  <= 1'b0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         rdwr_q  <= rdwr_d;
         proto_q <= proto_d;
      end
   end

   assign busy         = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   assign err_timeout  = to_q;
   assign err_rdwr     = rdwr_q;
   assign err_proto    = proto_q;
   assign err_any_next = to_d | rdwr_d | proto_d;
   assign txn_done_cnt = cnt_q;

endmodule

// File: rtl/cpu_lv1_protocol_monitor.sv
// Passive CPU-to-L1 protocol monitor: one tracker per core plus global
// proc-grant sanity checks and a registered any-error summary.
module cpu_lv1_protocol_monitor
   import cpu_lv1_mon_pkg::*;
#(
   parameter int unsigned NUM_CORES     = 4,
   parameter int unsigned ADDR_WID      = 32,
   parameter int unsigned READ_TIMEOUT  = DEF_READ_TIMEOUT,
   parameter int unsigned WRITE_TIMEOUT = DEF_WRITE_TIMEOUT,
   parameter int unsigned CNT_WID       = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   cpu_lv1_protocol_monitor_if.slave    mon,
   input  logic                         clr_err,
   output logic [NUM_CORES-1:0]         busy,
   output logic [NUM_CORES-1:0]         err_timeout,
   output logic [NUM_CORES-1:0]         err_rdwr,
   output logic [NUM_CORES-1:0]         err_proto,
   output logic                         err_multi_gnt,
   output logic                         err_gnt_no_req,
   output logic                         any_err,
   output logic [NUM_CORES*CNT_WID-1:0] txn_done_cnt
);

   logic [NUM_CORES-1:0] core_any_next;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      cpu_lv1_core_tracker #(
         .ADDR_WID      (ADDR_WID),
         .READ_TIMEOUT  (READ_TIMEOUT),
         .WRITE_TIMEOUT (WRITE_TIMEOUT),
         .CNT_WID       (CNT_WID)
      ) u_tracker (
         .clk                 (clk),
         .rst_n               (rst_n),
         .cpu_rd              (mon.cpu_rd[i]),
         .cpu_wr              (mon.cpu_wr[i]),
         .cpu_wr_done         (mon.cpu_wr_done[i]),
         .data_in_bus_cpu_lv1 (mon.data_in_bus_cpu_lv1[i]),
         .addr                (mon.addr_bus_cpu_lv1[i*ADDR_WID +: ADDR_WID]),
         .clr_err             (clr_err),
         .busy                (busy[i]),
         .err_timeout         (err_timeout[i]),
         .err_rdwr            (err_rdwr[i]),
         .err_proto           (err_proto[i]),
         .err_any_next        (core_any_next[i]),
         .txn_done_cnt        (txn_done_cnt[i*CNT_WID +: CNT_WID])
      );
   end

   logic multi_q, multi_d;
   logic gnr_q, gnr_d;
   logic any_q, any_d;

   always_comb begin
      multi_d = (multi_q & ~clr_err) | !$onehot0(mon.bus_lv1_lv2_gnt_proc);
      gnr_d   = (gnr_q & ~clr_err)
              | (|(mon.bus_lv1_lv2_gnt_proc & ~mon.bus_lv1_lv2_req_proc));
      // Built from next-state flags so any_err lines up with the flags.
      any_d   = (|core_any_next) | multi_d | gnr_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         multi_q <= 1'b0;
         gnr_q   <= 1'b0;
         any_q   <= 1'b0;
      end else begin
         multi_q <= multi_d;
         gnr_q   <= gnr_d;
         any_q   <= any_d;
      end
   end

   assign err_multi_gnt  = multi_q;
   assign err_gnt_no_req = gnr_q;
   assign any_err        = any_q;

endmodule

// File: tb/tb_cpu_lv1_protocol_monitor.sv
// Directed bench for cpu_lv1_protocol_monitor with a queue-based scoreboard.
module tb_cpu_lv1_protocol_monitor;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_err = 1'b0;

   logic [NC-1:0]    busy, err_timeout, err_rdwr, err_proto;
   logic             err_multi_gnt, err_gnt_no_req, any_err;
   logic [NC*CW-1:0] txn_done_cnt;

   cpu_lv1_protocol_monitor_if #(.NUM_CORES(NC), .ADDR_WID(AW)) mon_if ();

   cpu_lv1_protocol_monitor #(
      .NUM_CORES     (NC),
      .ADDR_WID      (AW),
      .READ_TIMEOUT  (80),
      .WRITE_TIMEOUT (90),
      .CNT_WID       (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mon            (mon_if),
      .clr_err        (clr_err),
      .busy           (busy),
      .err_timeout    (err_timeout),
      .err_rdwr       (err_rdwr),
      .err_proto      (err_proto),
      .err_multi_gnt  (err_multi_gnt),
      .err_gnt_no_req (err_gnt_no_req),
      .any_err        (any_err),
      .txn_done_cnt   (txn_done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NC-1:0]    busy;
      logic [NC-1:0]    to;
      logic [NC-1:0]    rdwr;
      logic [NC-1:0]    proto;
      logic             multi;
      logic             gnr;
      logic             any;
      logic [NC*CW-1:0] cnt;
   } snap_t;

   snap_t exp_q[$];
   string name_q[$];
   snap_t e;
   int    checks = 0;
   int    errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm);
      e.any = |{e.to, e.rdwr, e.proto, e.multi, e.gnr};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Scoreboard monitor: pops pending expectations away from the clock edge.
   initial begin : mon_blk
      snap_t x, a;
      string n;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n = name_q.pop_front();
            a.busy  = busy;
            a.to    = err_timeout;
            a.rdwr  = err_rdwr;
            a.proto = err_proto;
            a.multi = err_multi_gnt;
            a.gnr   = err_gnt_no_req;
            a.any   = any_err;
            a.cnt   = txn_done_cnt;
            checks++;
            if (a !== x) begin
               errors++;
               $display("FAIL %s: got busy=%b to=%b rdwr=%b proto=%b mg=%b gnr=%b any=%b cnt=%h; exp busy=%b to=%b rdwr=%b proto=%b mg=%b gnr=%b any=%b cnt=%h",
                        n, a.busy, a.to, a.rdwr, a.proto, a.multi, a.gnr, a.any, a.cnt,
                        x.busy, x.to, x.rdwr, x.proto, x.multi, x.gnr, x.any, x.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mon_if.cpu_rd               = '0;
      mon_if.cpu_wr               = '0;
      mon_if.cpu_wr_done          = '0;
      mon_if.data_in_bus_cpu_lv1  = '0;
      mon_if.addr_bus_cpu_lv1     = '0;
      mon_if.bus_lv1_lv2_req_proc = '0;
      mon_if.bus_lv1_lv2_gnt_proc = '0;
      e = '0;

      repeat (2) tick();
      chk("reset");
      rst_n = 1'b1;
      tick();
      chk("idle after reset");

      // 1: core 2 read completes on cycle 5
      mon_if.addr_bus_cpu_lv1[2*AW +: AW] = 32'h0000_1000;
      mon_if.cpu_rd[2] = 1'b1;
      tick();
      e.busy = 4'b0100;
      chk("t1 accept");
      repeat (4) tick();
      chk("t1 cycle 4 busy");
      mon_if.data_in_bus_cpu_lv1[2] = 1'b1;
      tick();
      e.busy = 4'b0000;
      e.cnt[2*CW +: CW] = 16'd1;
      chk("t1 done");
      mon_if.data_in_bus_cpu_lv1[2] = 1'b0;
      mon_if.cpu_rd[2] = 1'b0;
      tick();
      chk("t1 idle");

      // 2: core 0 write timeout
      mon_if.addr_bus_cpu_lv1[0 +: AW] = 32'h0000_2000;
      mon_if.cpu_wr[0] = 1'b1;
      tick();
      e.busy = 4'b0001;
      chk("t2 accept");
      repeat (89) tick();
      chk("t2 cycle 89 no timeout");
      tick();
      e.busy = 4'b0000;
      e.to[0] = 1'b1;
      chk("t2 timeout");
      repeat (9) tick();
      chk("t2 hold");
      mon_if.cpu_wr[0] = 1'b0;
      tick();
      chk("t2 idle");
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      e.to = '0;
      chk("t2 cleared");

      // 3: core 1 read boundary
      mon_if.addr_bus_cpu_lv1[1*AW +: AW] = 32'h0000_3000;
      mon_if.cpu_rd[1] = 1'b1;
      tick();
      e.busy = 4'b0010;
      chk("t3 accept");
      repeat (79) tick();
      mon_if.data_in_bus_cpu_lv1[1] = 1'b1;
      tick();
      e.busy = 4'b0000;
      e.cnt[1*CW +: CW] = 16'd1;
      chk("t3 data at cycle 80");
      mon_if.data_in_bus_cpu_lv1[1] = 1'b0;
      mon_if.cpu_rd[1] = 1'b0;
      tick();
      chk("t3 idle");
      mon_if.cpu_rd[1] = 1'b1;
      tick();
      e.busy = 4'b0010;
      chk("t3 second accept");
      repeat (80) tick();
      e.busy = 4'b0000;
      e.to[1] = 1'b1;
      chk("t3 timeout at cycle 80");
      mon_if.data_in_bus_cpu_lv1[1] = 1'b1;
      tick();
      chk("t3 data at cycle 81 ignored");
      mon_if.data_in_bus_cpu_lv1[1] = 1'b0;
      mon_if.cpu_rd[1] = 1'b0;
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      e.to = '0;
      chk("t3 cleared");

      // 4: core 3 simultaneous rd and wr
      mon_if.cpu_rd[3] = 1'b1;
      mon_if.cpu_wr[3] = 1'b1;
      tick();
      e.rdwr[3] = 1'b1;
      chk("t4 rdwr");
      mon_if.cpu_rd[3] = 1'b0;
      mon_if.cpu_wr[3] = 1'b0;
      tick();
      chk("t4 still idle");
      mon_if.addr_bus_cpu_lv1[3*AW +: AW] = 32'h0000_0040;
      mon_if.cpu_wr[3] = 1'b1;
      tick();
      e.busy = 4'b1000;
      chk("t4 write accept");
      mon_if.cpu_wr_done[3] = 1'b1;
      tick();
      e.busy = 4'b0000;
      e.cnt[3*CW +: CW] = 16'd1;
      chk("t4 write done");
      mon_if.cpu_wr_done[3] = 1'b0;
      mon_if.cpu_wr[3] = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      e.rdwr = '0;
      chk("t4 cleared");

      // 5: grant checks
      mon_if.bus_lv1_lv2_req_proc = 4'b0110;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b0110;
      tick();
      e.multi = 1'b1;
      chk("t5 multi gnt");
      mon_if.bus_lv1_lv2_req_proc = 4'b0000;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b1000;
      tick();
      e.gnr = 1'b1;
      chk("t5 gnt no req");
      mon_if.bus_lv1_lv2_req_proc = 4'b0100;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b0100;
      tick();
      chk("t5 sticky");
      clr_err = 1'b1;
      mon_if.bus_lv1_lv2_req_proc = 4'b0000;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b1000;
      tick();
      e.multi = 1'b0;
      chk("t5 new err beats clr");
      mon_if.bus_lv1_lv2_gnt_proc = 4'b0000;
      tick();
      clr_err = 1'b0;
      e.gnr = 1'b0;
      chk("t5 cleared");
      mon_if.bus_lv1_lv2_req_proc = 4'b0110;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b0100;
      tick();
      chk("t5 legal grant");
      mon_if.bus_lv1_lv2_req_proc = 4'b0000;
      mon_if.bus_lv1_lv2_gnt_proc = 4'b0000;

      // 6: core 2 address change, then async reset mid-transaction on core 0
      mon_if.addr_bus_cpu_lv1[2*AW +: AW] = 32'h0000_0100;
      mon_if.cpu_rd[2] = 1'b1;
      tick();
      e.busy = 4'b0100;
      chk("t6 accept");
      tick();
      mon_if.addr_bus_cpu_lv1[2*AW +: AW] = 32'h0000_0104;
      tick();
      e.busy = 4'b0000;
      e.proto[2] = 1'b1;
      chk("t6 addr change");
      mon_if.cpu_rd[2] = 1'b0;
      tick();
      chk("t6 idle");
      mon_if.addr_bus_cpu_lv1[0 +: AW] = 32'h0000_0500;
      mon_if.cpu_rd[0] = 1'b1;
      tick();
      e.busy = 4'b0001;
      chk("t6 core 0 accept");
      tick();
      #2;
      rst_n = 1'b0;
      mon_if.cpu_rd[0] = 1'b0;
      e = '0;
      chk("t6 async reset");
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t6 after reset");

      repeat (2) tick();
      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL scoreboard drain: got %0d pending, exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
